// File: rtl/yrv_mem_arbiter.sv
// rtl/yrv_mem_arbiter.sv - two-master (CPU/DMA) round-robin arbiter for the YRV memory port
// Grant is a registered state; slave-side request and master-side responses are muxed from it.

module yrv_mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [1:0]  c_trans,
  input  logic        c_lock,
  input  logic        c_write,
  input  logic [3:0]  c_ble,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ready,
  output logic [31:0] c_rdata,
  input  logic [1:0]  d_trans,
  input  logic        d_lock,
  input  logic        d_write,
  input  logic [3:0]  d_ble,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [1:0]  s_trans,
  output logic        s_lock,
  output logic        s_write,
  output logic [3:0]  s_ble,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        gnt_cpu,
  output logic        gnt_dma
);

  typedef enum logic [1:0] {IDLE, GNT_C, GNT_D} state_t;

  localparam logic [4:0] MAX_B = 5'(MAX_BURST);

  state_t     state_q, state_d;
  logic       last_dma_q, last_dma_d;
  logic [3:0] burst_q, burst_d;

  logic       c_req, d_req;
  logic       own_req, own_lock, oth_req, done, burst_full;
  logic [3:0] burst_inc;
  state_t     own_st, oth_st;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      last_dma_q <= 1'b1;
      burst_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      burst_q    <= burst_d;
    end
  end

  assign c_req      = |c_trans;
  assign d_req      = |d_trans;
  assign burst_inc  = (burst_q == 4'd15) ? 4'd15 : burst_q + 4'd1;
  assign burst_full = ({1'b0, burst_q} + 5'd1) >= MAX_B;

  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    own_st   = state_q;
    oth_st   = IDLE;
    if (state_q == GNT_C) begin
      own_req  = c_req;
      own_lock = c_lock;
      oth_req  = d_req;
      oth_st   = GNT_D;
    end else if (state_q == GNT_D) begin
      own_req  = d_req;
      own_lock = d_lock;
      oth_req  = c_req;
      oth_st   = GNT_C;
    end
  end

  // A transfer completes only when the slave answers a live request of the granted master
  assign done = (state_q != IDLE) && s_ready && own_req;

  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    burst_d    = burst_q;
    case (state_q)
      IDLE: begin
        burst_d = 4'd0;
        if (c_req && d_req) state_d = last_dma_q ? GNT_C : GNT_D;
        else if (c_req)     state_d = GNT_C;
        else if (d_req)     state_d = GNT_D;
      end
      GNT_C, GNT_D: begin
        if (done) begin
          last_dma_d = (state_q == GNT_D);
          if (own_lock) begin
            burst_d = burst_inc;
          end else if (oth_req && burst_full) begin
            state_d = oth_st;
            burst_d = 4'd0;
          end else if (own_req && !burst_full) begin
            burst_d = burst_inc;
          end else if (oth_req) begin
            state_d = oth_st;
            burst_d = 4'd0;
          end else begin
            state_d = IDLE;
            burst_d = 4'd0;
          end
        end else if (!own_req && !own_lock) begin
          state_d = IDLE;
          burst_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    s_trans = 2'b00;
    s_lock  = 1'b0;
    s_write = 1'b0;
    s_ble   = 4'h0;
    s_addr  = 32'h0;
    s_wdata = 32'h0;
    c_ready = 1'b0;
    c_rdata = 32'h0;
    d_ready = 1'b0;
    d_rdata = 32'h0;
    if (state_q == GNT_C) begin
      s_trans = c_trans;
      s_lock  = c_lock;
      s_write = c_write;
      s_ble   = c_ble;
      s_addr  = c_addr;
      s_wdata = c_wdata;
      c_ready = s_ready && c_req;
      c_rdata = s_rdata;
    end else if (state_q == GNT_D) begin
      s_trans = d_trans;
      s_lock  = d_lock;
      s_write = d_write;
      s_ble   = d_ble;
      s_addr  = d_addr;
      s_wdata = d_wdata;
      d_ready = s_ready && d_req;
      d_rdata = s_rdata;
    end
  end

  assign gnt_cpu = (state_q == GNT_C);
  assign gnt_dma = (state_q == GNT_D);

endmodule

// File: tb/tb_yrv_mem_arbiter.sv
// tb/tb_yrv_mem_arbiter.sv - scoreboard bench for yrv_mem_arbiter with a wait-state slave model

module tb_yrv_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetb;
  logic [1:0]  c_trans, d_trans, s_trans;
  logic        c_lock, c_write, d_lock, d_write, s_lock, s_write;
  logic [3:0]  c_ble, d_ble, s_ble;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, s_addr, s_wdata;
  logic        c_ready, d_ready, s_ready, gnt_cpu, gnt_dma;
  logic [31:0] c_rdata, d_rdata, s_rdata;

  always #5 clk = ~clk;

  yrv_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .resetb(resetb),
    .c_trans(c_trans), .c_lock(c_lock), .c_write(c_write), .c_ble(c_ble),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready), .c_rdata(c_rdata),
    .d_trans(d_trans), .d_lock(d_lock), .d_write(d_write), .d_ble(d_ble),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .s_trans(s_trans), .s_lock(s_lock), .s_write(s_write), .s_ble(s_ble),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
    .gnt_cpu(gnt_cpu), .gnt_dma(gnt_dma)
  );

  // Slave read data folds every request field in, so a wrong mux shows up in rdata
  localparam logic [31:0] KEY = 32'hDEADBF60;

  typedef struct {
    bit          dma;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   ws = 0;
  bit   force_rdy = 1'b0;

  function automatic logic [31:0] model(input logic [1:0] tr, input logic lk, input logic wr,
                                        input logic [3:0] ble, input logic [31:0] a,
                                        input logic [31:0] wd);
    return a ^ KEY ^ (wr ? wd : 32'h0) ^ {lk, 23'h0, tr, 2'b00, ble};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit dma, input logic [1:0] tr, input logic lk, input logic wr,
                      input logic [3:0] ble, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.dma   = dma;
    e.rdata = model(tr, lk, wr, ble, a, wd);
    sbq.push_back(e);
  endtask

  task automatic xfer(input bit dma, input logic [1:0] tr, input logic lk, input logic wr,
                      input logic [3:0] ble, input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    if (dma) begin
      d_trans = tr; d_lock = lk; d_write = wr; d_ble = ble; d_addr = a; d_wdata = wd;
    end else begin
      c_trans = tr; c_lock = lk; c_write = wr; c_ble = ble; c_addr = a; c_wdata = wd;
    end
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk); #2;
      got = dma ? d_ready : c_ready;
    end
    check(dma ? "dma_xfer_done" : "cpu_xfer_done", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    if (dma) d_trans = 2'b00;
    else     c_trans = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Slave: answers after ws wait states, then drops ready for at least one cycle
  initial begin
    int scnt;
    scnt = 0;
    s_ready = 1'b0;
    s_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (force_rdy) begin
        s_ready = 1'b1;
      end else if (s_ready) begin
        s_ready = 1'b0;
        scnt = 0;
      end else if (s_trans == 2'b00) begin
        scnt = 0;
      end else if (scnt >= ws) begin
        s_ready = 1'b1;
        s_rdata = model(s_trans, s_lock, s_write, s_ble, s_addr, s_wdata);
      end else begin
        scnt++;
      end
    end
  end

  // Monitor: every ready pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      check("gnt_exclusive", {31'h0, gnt_cpu & gnt_dma}, 32'h0);
      if (c_ready || d_ready) begin
        if (c_ready && d_ready) begin
          check("both_ready", 32'h1, 32'h0);
        end else if (sbq.size() == 0) begin
          check("unexpected_ready", {30'h0, d_ready, c_ready}, 32'h0);
        end else begin
          e = sbq.pop_front();
          check("ready_master_is_dma", {31'h0, d_ready}, {31'h0, e.dma});
          check("rdata", d_ready ? d_rdata : c_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    resetb = 1'b0;
    c_trans = 2'b00; c_lock = 1'b0; c_write = 1'b0; c_ble = 4'h0; c_addr = 32'h0; c_wdata = 32'h0;
    d_trans = 2'b00; d_lock = 1'b0; d_write = 1'b0; d_ble = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    idle(3);
    check("rst_gnt_cpu", {31'h0, gnt_cpu}, 32'h0);
    check("rst_gnt_dma", {31'h0, gnt_dma}, 32'h0);
    check("rst_s_trans", {30'h0, s_trans}, 32'h0);
    check("rst_s_lock", {31'h0, s_lock}, 32'h0);
    check("rst_readies", {30'h0, c_ready, d_ready}, 32'h0);
    resetb = 1'b1;
    idle(2);

    // s_ready with nobody requesting
    force_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk); #3;
      check("t6_idle_gnt", {30'h0, gnt_cpu, gnt_dma}, 32'h0);
      check("t6_idle_s_trans", {30'h0, s_trans}, 32'h0);
    end
    force_rdy = 1'b0;
    idle(2);

    // First tie after reset goes to CPU, then DMA
    ws = 1;
    push(0, 2'b01, 0, 0, 4'hF, 32'h0000_0200, 32'h0);
    push(1, 2'b11, 0, 1, 4'h3, 32'h0000_0300, 32'h1234_5678);
    fork
      xfer(0, 2'b01, 0, 0, 4'hF, 32'h0000_0200, 32'h0);
      xfer(1, 2'b11, 0, 1, 4'h3, 32'h0000_0300, 32'h1234_5678);
    join
    idle(2);

    // CPU read alone: registered grant, two wait states, fixed read data
    ws = 2;
    sbq.push_back('{dma: 1'b0, rdata: 32'hDEADBEEF});
    fork
      xfer(0, 2'b10, 0, 0, 4'hF, 32'h0000_0100, 32'h0);
      begin
        @(negedge clk); #1;
        check("t1_s_trans_before_grant", {30'h0, s_trans}, 32'h0);
        @(posedge clk); #1;
        check("t1_s_trans_granted", {30'h0, s_trans}, 32'h2);
        check("t1_s_addr", s_addr, 32'h0000_0100);
        check("t1_gnt_cpu", {31'h0, gnt_cpu}, 32'h1);
      end
    join
    idle(2);

    // Last served was CPU, so this tie goes to DMA
    ws = 1;
    push(1, 2'b01, 0, 0, 4'hF, 32'h0000_0310, 32'h0);
    push(0, 2'b01, 0, 1, 4'hC, 32'h0000_0210, 32'hA5A5_5A5A);
    fork
      xfer(1, 2'b01, 0, 0, 4'hF, 32'h0000_0310, 32'h0);
      xfer(0, 2'b01, 0, 1, 4'hC, 32'h0000_0210, 32'hA5A5_5A5A);
    join
    idle(2);

    // CPU streams 10, DMA has two single transfers: C4 D C4 D C2
    ws = 0;
    for (int i = 0; i < 4; i++) push(0, 2'b01, 0, 0, 4'hF, 32'h1000 + 32'(4 * i), 32'h0);
    push(1, 2'b10, 0, 0, 4'hF, 32'h2000, 32'h0);
    for (int i = 4; i < 8; i++) push(0, 2'b01, 0, 0, 4'hF, 32'h1000 + 32'(4 * i), 32'h0);
    push(1, 2'b10, 0, 0, 4'hF, 32'h2004, 32'h0);
    for (int i = 8; i < 10; i++) push(0, 2'b01, 0, 0, 4'hF, 32'h1000 + 32'(4 * i), 32'h0);
    fork
      for (int i = 0; i < 10; i++) xfer(0, 2'b01, 0, 0, 4'hF, 32'h1000 + 32'(4 * i), 32'h0);
      begin
        idle(1);
        xfer(1, 2'b10, 0, 0, 4'hF, 32'h2000, 32'h0);
        idle(1);
        xfer(1, 2'b10, 0, 0, 4'hF, 32'h2004, 32'h0);
      end
    join
    idle(2);

    // Locked RMW holds DMA off, including idle cycles with lock still high
    ws = 1;
    push(0, 2'b01, 1, 0, 4'hF, 32'h0000_3000, 32'h0);
    push(0, 2'b01, 0, 1, 4'h6, 32'h0000_3000, 32'hCAFE_F00D);
    push(1, 2'b01, 0, 0, 4'hF, 32'h0000_4000, 32'h0);
    fork
      begin
        xfer(0, 2'b01, 1, 0, 4'hF, 32'h0000_3000, 32'h0);
        repeat (2) begin
          @(posedge clk); #1;
          check("t3_lock_holds_cpu", {30'h0, gnt_cpu, gnt_dma}, 32'h2);
        end
        xfer(0, 2'b01, 0, 1, 4'h6, 32'h0000_3000, 32'hCAFE_F00D);
      end
      begin
        idle(1);
        xfer(1, 2'b01, 0, 0, 4'hF, 32'h0000_4000, 32'h0);
      end
    join
    idle(2);

    // Make CPU the last served, then reset in the middle of a wait-stated transfer
    push(0, 2'b01, 0, 0, 4'hF, 32'h0000_5000, 32'h0);
    xfer(0, 2'b01, 0, 0, 4'hF, 32'h0000_5000, 32'h0);
    idle(2);
    ws = 6;
    c_trans = 2'b01; c_lock = 1'b0; c_write = 1'b0; c_addr = 32'h0000_5100;
    for (int n = 0; n < 10 && !gnt_cpu; n++) idle(1);
    check("t5_granted_before_reset", {31'h0, gnt_cpu}, 32'h1);
    idle(2);
    resetb = 1'b0;
    #1;
    check("t5_reset_s_trans", {30'h0, s_trans}, 32'h0);
    check("t5_reset_gnt", {30'h0, gnt_cpu, gnt_dma}, 32'h0);
    check("t5_reset_c_ready", {31'h0, c_ready}, 32'h0);
    idle(2);
    c_trans = 2'b00;
    idle(1);
    resetb = 1'b1;
    ws = 1;
    idle(1);
    push(0, 2'b01, 0, 0, 4'hF, 32'h0000_5200, 32'h0);
    push(1, 2'b01, 0, 0, 4'hF, 32'h0000_5300, 32'h0);
    fork
      xfer(0, 2'b01, 0, 0, 4'hF, 32'h0000_5200, 32'h0);
      xfer(1, 2'b01, 0, 0, 4'hF, 32'h0000_5300, 32'h0);
    join

    for (int n = 0; n < 100 && sbq.size() != 0; n++) idle(1);
    idle(3);
    check("scoreboard_drained", sbq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
